axis_rr_byte_arbiter: RTL and testbench

AXIS_RR_BYTE_ARBITER -- requirements
Module: axis_rr_byte_arbiter

---
 rtl/axis_rr_byte_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axis_rr_byte_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_byte_arbiter.sv
// Round-robin gatherer: packs bytes from one granted byte FIFO into an AXIS word, LSB lane first.
// A starved partial word is flushed after TIMEOUT idle cycles; the output word is held until tready.
module axis_rr_byte_arbiter #(
  parameter int LOGIC_SIZE = 32,
  parameter int NUM_SRC    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_reset,
  input  logic [NUM_SRC*8-1:0]         i_from_fifo,
  input  logic [NUM_SRC-1:0]           r_empty,
  output logic [NUM_SRC-1:0]           r_req,
  output logic [LOGIC_SIZE-1:0]        m_axis_tdata,
  output logic [LOGIC_SIZE/8-1:0]      m_axis_tkeep,
  output logic [$clog2(NUM_SRC)-1:0]   m_axis_tdest,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         busy
);

  localparam int BYTES = LOGIC_SIZE / 8;
  localparam int IDW   = $clog2(NUM_SRC);
  localparam int CW    = $clog2(BYTES);
  localparam int TW    = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(BYTES - 1);
  localparam logic [TW-1:0]  TMR_LAST   = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] GRANT_INIT = IDW'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, GATHER, SEND} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   grant, last_grant;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;

  logic             rr_found;
  logic [IDW-1:0]   rr_pick;
  logic             pop;
  logic [7:0]       pop_byte;
  logic [BYTES-1:0] keep_part;

  // Circular search starting just after the last served source.
  always_comb begin : rr_search
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (!rr_found && !r_empty[idx]) begin
        rr_found = 1'b1;
        rr_pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    keep_part = '0;
    for (int b = 0; b < BYTES; b++) begin
      keep_part[b] = (b < int'(cnt));
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = (state == GATHER) && !r_empty[grant];
    pop_byte  = i_from_fifo[{grant, 3'b000} +: 8];
    r_req     = '0;
    if (pop) begin
      r_req[grant] = 1'b1;
    end
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt = GATHER;
        end
      end
      GATHER: begin
        if (pop) begin
          if (cnt == CNT_LAST) begin
            state_nxt = SEND;
          end
        end else if (timer == TMR_LAST) begin
          state_nxt = (cnt != '0) ? SEND : IDLE;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The output data register doubles as the assembly buffer; it is zero whenever no word is pending.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_reset) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tvalid <= 1'b0;
      cnt           <= '0;
      timer         <= '0;
      grant         <= '0;
      last_grant    <= GRANT_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant <= rr_pick;
            cnt   <= '0;
            timer <= '0;
          end
        end
        GATHER: begin
          if (pop) begin
            m_axis_tdata[{cnt, 3'b000} +: 8] <= pop_byte;
            cnt   <= cnt + 1'b1;
            timer <= '0;
            if (cnt == CNT_LAST) begin
              m_axis_tkeep  <= '1;
              m_axis_tdest  <= grant;
              m_axis_tvalid <= 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            if (cnt != '0) begin
              m_axis_tkeep  <= keep_part;
              m_axis_tdest  <= grant;
              m_axis_tvalid <= 1'b1;
            end else begin
              last_grant <= grant;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            cnt           <= '0;
            last_grant    <= grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_rr_byte_arbiter.sv
// Directed bench for axis_rr_byte_arbiter: byte-FIFO models, per-source byte scoreboard,
// a table of single-word vectors, and hand-written multi-cycle sequences.
module tb_axis_rr_byte_arbiter;
  localparam int LS = 32;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int BY = LS / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS*8-1:0] din;
  logic [NS-1:0] r_empty;
  logic [NS-1:0] r_req;
  logic [LS-1:0] tdata;
  logic [BY-1:0] tkeep;
  logic [1:0]    tdest;
  logic          tvalid;
  logic          tready;
  logic          busy;

  always #5 clk = ~clk;

  axis_rr_byte_arbiter #(.LOGIC_SIZE(LS), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .s_axis_aclk  (clk),
    .s_axis_reset (rst),
    .i_from_fifo  (din),
    .r_empty      (r_empty),
    .r_req        (r_req),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tdest (tdest),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy         (busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [1:0]  t;
  } word_t;

  typedef struct {
    int          src;
    int          n;
    logic [31:0] b;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic [1:0]  et;
  } vec_t;

  logic [7:0] fq [NS][$];
  logic [7:0] eq [NS][$];
  word_t      got[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int src, input logic [7:0] b);
    fq[src].push_back(b);
    eq[src].push_back(b);
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      eq[i].delete();
    end
  endtask

  // Show-ahead FIFO outputs refresh on the falling edge, so they are stable at every rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      r_empty[i] = (fq[i].size() == 0);
      din[i*8 +: 8] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (r_req[i] === 1'b1) begin
        chk("no_pop_on_empty", 64'(fq[i].size() == 0), 64'd0);
        if (fq[i].size() > 0) void'(fq[i].pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && tvalid === 1'b1 && tready === 1'b1) begin
      got.push_back({tdata, tkeep, tdest});
      for (int b = 0; b < BY; b++) begin
        if (tkeep[b]) begin
          chk("sb_byte_avail", 64'(eq[tdest].size() != 0), 64'd1);
          if (eq[tdest].size() != 0) chk("sb_byte", 64'(tdata[b*8 +: 8]), 64'(eq[tdest].pop_front()));
        end else begin
          chk("sb_pad_zero", 64'(tdata[b*8 +: 8]), 64'd0);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    flush();
    got.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_word(input int maxc, output word_t w, output bit ok);
    ok = 1'b0;
    w = '0;
    for (int c = 0; c < maxc && !ok; c++) begin
      if (got.size() > 0) begin
        w = got.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("word_arrived", 64'(ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t  vt[5];
  word_t w;
  bit    ok;
  int    c, n;
  int    left;
  logic [31:0] exp_d;

  initial begin
    vt[0] = '{2, 4, 32'h44332211, 32'h44332211, 4'hF, 2'd2};
    vt[1] = '{1, 2, 32'h5A5ABBAA, 32'h0000BBAA, 4'h3, 2'd1};
    vt[2] = '{0, 4, 32'h04030201, 32'h04030201, 4'hF, 2'd0};
    vt[3] = '{3, 1, 32'h0000005A, 32'h0000005A, 4'h1, 2'd3};
    vt[4] = '{3, 3, 32'h77BEADDE, 32'h00BEADDE, 4'h7, 2'd3};

    rst = 1'b1;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata",  64'(tdata),  64'd0);
    chk("rst_tkeep",  64'(tkeep),  64'd0);
    chk("rst_tdest",  64'(tdest),  64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_req",    64'(r_req),  64'd0);
    rst = 1'b0;

    // Table of single-source words, full and timed-out partial.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int k = 0; k < vt[v].n; k++) push(vt[v].src, vt[v].b[k*8 +: 8]);
      wait_word(60, w, ok);
      chk($sformatf("vec%0d_tdata", v), 64'(w.d), 64'(vt[v].ed));
      chk($sformatf("vec%0d_tkeep", v), 64'(w.k), 64'(vt[v].ek));
      chk($sformatf("vec%0d_tdest", v), 64'(w.t), 64'(vt[v].et));
    end

    // Pop run length and one-cycle valid for a never-starving source.
    do_reset();
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33); push(2, 8'h44);
    c = 0;
    while (r_req == '0 && c < 10) begin @(posedge clk); #1; c++; end
    chk("a_detect_cycles", 64'(c), 64'd1);
    chk("a_busy", 64'(busy), 64'd1);
    n = 0;
    while (r_req == 4'b0100 && n < 10) begin n++; @(posedge clk); #1; end
    chk("a_req_run", 64'(n), 64'd4);
    chk("a_tvalid", 64'(tvalid), 64'd1);
    chk("a_tdata", 64'(tdata), 64'h44332211);
    chk("a_tkeep", 64'(tkeep), 64'hF);
    chk("a_tdest", 64'(tdest), 64'd2);
    chk("a_req_send", 64'(r_req), 64'd0);
    @(posedge clk); #1;
    chk("a_tvalid_drop", 64'(tvalid), 64'd0);
    chk("a_idle", 64'(busy), 64'd0);

    // All sources busy: strict rotation, each word from one source.
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 8; k++) push(s, 8'((s << 4) | k));
    for (int j = 0; j < 8; j++) begin
      exp_d = 32'h0;
      for (int k = 0; k < 4; k++) exp_d[k*8 +: 8] = 8'(((j % 4) << 4) | ((j / 4) * 4 + k));
      wait_word(40, w, ok);
      chk($sformatf("rot%0d_tdest", j), 64'(w.t), 64'(j % 4));
      chk($sformatf("rot%0d_tdata", j), 64'(w.d), 64'(exp_d));
    end

    // Backpressure: word held, no pops while another source waits.
    do_reset();
    tready = 1'b0;
    for (int k = 0; k < 4; k++) begin push(0, 8'(k + 1)); push(1, 8'(8'hA1 + k)); end
    c = 0;
    while (tvalid !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
    chk("c_tvalid_up", 64'(tvalid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("c_hold_tvalid", 64'(tvalid), 64'd1);
      chk("c_hold_tdata",  64'(tdata),  64'h04030201);
      chk("c_hold_tkeep",  64'(tkeep),  64'hF);
      chk("c_hold_tdest",  64'(tdest),  64'd0);
      chk("c_hold_req",    64'(r_req),  64'd0);
      @(posedge clk); #1;
    end
    chk("c_no_early_xfer", 64'(got.size()), 64'd0);
    tready = 1'b1;
    @(posedge clk); #1;
    chk("c_xfer_count", 64'(got.size()), 64'd1);
    wait_word(5, w, ok);
    chk("c_first_tdest", 64'(w.t), 64'd0);
    wait_word(40, w, ok);
    chk("c_second_tdest", 64'(w.t), 64'd1);
    chk("c_second_tdata", 64'(w.d), 64'hA4A3A2A1);

    // Reset in mid-gather drops the partial word; priority returns to source 0.
    do_reset();
    push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3); push(2, 8'hC4);
    c = 0;
    while (r_req == '0 && c < 10) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("d_popped_two", 64'(fq[2].size()), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("d_tvalid", 64'(tvalid), 64'd0);
    chk("d_busy",   64'(busy),   64'd0);
    chk("d_req",    64'(r_req),  64'd0);
    flush();
    got.delete();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin push(2, 8'(8'hD1 + k)); push(0, 8'(8'hE1 + k)); end
    wait_word(40, w, ok);
    chk("d_first_tdest", 64'(w.t), 64'd0);
    chk("d_first_tdata", 64'(w.d), 64'hE4E3E2E1);
    wait_word(40, w, ok);
    chk("d_second_tdest", 64'(w.t), 64'd2);
    chk("d_second_tdata", 64'(w.d), 64'hD4D3D2D1);

    // Random traffic and stalls; the scoreboard checks every delivered byte.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, NS - 1)), 8'($urandom));
      @(posedge clk); #1;
    end
    tready = 1'b1;
    c = 0;
    left = 1;
    while (left != 0 && c < 20000) begin
      left = 0;
      for (int s = 0; s < NS; s++) left += eq[s].size();
      if (busy) left++;
      @(posedge clk); #1;
      c++;
    end
    chk("e_drained", 64'(left), 64'd0);
    got.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
